// File: rtl/id_ex_stage_if.sv
// Handshake and operand bus between decode, the ID/EX stage and the ALU.
interface id_ex_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_aluop;
    logic            in_rtype;
    logic            in_funct7_5;
    logic [2:0]      in_funct3;
    logic            in_alusrc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [RW-1:0]   in_rs1_addr;
    logic [RW-1:0]   in_rs2_addr;
    logic [RW-1:0]   in_rd_addr;
    logic            in_regwrite;
    logic            exmem_regwrite;
    logic            memwb_regwrite;
    logic [RW-1:0]   exmem_rd;
    logic [RW-1:0]   memwb_rd;
    logic [XLEN-1:0] exmem_result;
    logic [XLEN-1:0] memwb_result;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      ALUCtl;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] store_data;
    logic [RW-1:0]   rd_addr;
    logic            regwrite;
    logic            illegal;

    // Upstream/downstream environment side.
    modport master (
        output flush, in_valid, in_aluop, in_rtype, in_funct7_5, in_funct3, in_alusrc,
               in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_regwrite, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               exmem_result, memwb_result, out_ready,
        input  in_ready, out_valid, ALUCtl, rs1, rs2, store_data, rd_addr, regwrite, illegal
    );

    // Pipeline stage side.
    modport slave (
        input  flush, in_valid, in_aluop, in_rtype, in_funct7_5, in_funct3, in_alusrc,
               in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_regwrite, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               exmem_result, memwb_result, out_ready,
        output in_ready, out_valid, ALUCtl, rs1, rs2, store_data, rd_addr, regwrite, illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU-control decode, operand-B select, EX/MEM and
// MEM/WB forwarding, and MEM/WB snooping of a stalled entry.
module id_ex_stage (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 4;

    localparam logic [CW-1:0] CTL_AND = 4'b0000;
    localparam logic [CW-1:0] CTL_OR  = 4'b0001;
    localparam logic [CW-1:0] CTL_ADD = 4'b0010;
    localparam logic [CW-1:0] CTL_SUB = 4'b0110;
    localparam logic [CW-1:0] CTL_BAD = 4'b1111;

    logic            r_valid;
    logic [CW-1:0]   r_ctl;
    logic            r_illegal;
    logic            r_alusrc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RW-1:0]   r_rs1_addr;
    logic [RW-1:0]   r_rs2_addr;
    logic [RW-1:0]   r_rd_addr;
    logic            r_regwrite;

    logic            w_in_ready;
    logic            w_capture;
    logic            w_stall;
    logic            w_snoop_rs1;
    logic            w_snoop_rs2;
    logic [CW-1:0]   w_ctl;
    logic            w_illegal;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;
    assign w_stall    = r_valid && !bus.out_ready;

    // A held nonzero source matching the MEM/WB write is refreshed while stalled.
    assign w_snoop_rs1 = w_stall && bus.memwb_regwrite && (bus.memwb_rd != '0)
                         && (bus.memwb_rd == r_rs1_addr);
    assign w_snoop_rs2 = w_stall && bus.memwb_regwrite && (bus.memwb_rd != '0)
                         && (bus.memwb_rd == r_rs2_addr);

    // ALU control decode from aluop/funct3/funct7[5].
    always_comb begin
        w_ctl     = CTL_ADD;
        w_illegal = 1'b0;
        case (bus.in_aluop)
            2'b00: w_ctl = CTL_ADD;
            2'b01: w_ctl = CTL_SUB;
            2'b10: begin
                case (bus.in_funct3)
                    3'b000:  w_ctl = (bus.in_rtype && bus.in_funct7_5) ? CTL_SUB : CTL_ADD;
                    3'b111:  w_ctl = CTL_AND;
                    3'b110:  w_ctl = CTL_OR;
                    default: begin
                        w_ctl     = CTL_BAD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                w_ctl     = CTL_BAD;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Operand forwarding; EX/MEM wins over MEM/WB, x0 never forwards.
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs1_addr))
            w_rs1_fwd = bus.exmem_result;
        else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs1_addr))
            w_rs1_fwd = bus.memwb_result;

        w_rs2_fwd = r_rs2_data;
        if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs2_addr))
            w_rs2_fwd = bus.exmem_result;
        else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs2_addr))
            w_rs2_fwd = bus.memwb_result;
    end

    // Entry register: reset, flush, capture, drain, or hold with snoop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_ctl      <= CTL_ADD;
            r_illegal  <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_regwrite <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_ctl      <= w_ctl;
            r_illegal  <= w_illegal;
            r_alusrc   <= bus.in_alusrc;
            r_rs1_data <= bus.in_rs1_data;
            r_rs2_data <= bus.in_rs2_data;
            r_imm      <= bus.in_imm;
            r_rs1_addr <= bus.in_rs1_addr;
            r_rs2_addr <= bus.in_rs2_addr;
            r_rd_addr  <= bus.in_rd_addr;
            r_regwrite <= bus.in_regwrite;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end else begin
            if (w_snoop_rs1) r_rs1_data <= bus.memwb_result;
            if (w_snoop_rs2) r_rs2_data <= bus.memwb_result;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.ALUCtl     = r_ctl;
    assign bus.illegal    = r_illegal;
    assign bus.rs1        = w_rs1_fwd;
    assign bus.rs2        = r_alusrc ? r_imm : w_rs2_fwd;
    assign bus.store_data = w_rs2_fwd;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.regwrite   = r_regwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the single held entry.
    logic        m_valid;
    logic [3:0]  m_ctl;
    logic        m_ill;
    logic        m_alusrc;
    logic [31:0] m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;
    logic        m_rw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, ctl} for the decode table.
    function automatic logic [4:0] ref_decode(logic [1:0] op, logic [2:0] f3, logic rt, logic f7);
        if (op == 2'd0) return {1'b0, 4'b0010};
        if (op == 2'd1) return {1'b0, 4'b0110};
        if (op == 2'd3) return {1'b1, 4'b1111};
        if (f3 == 3'd0) return (rt && f7) ? {1'b0, 4'b0110} : {1'b0, 4'b0010};
        if (f3 == 3'd7) return {1'b0, 4'b0000};
        if (f3 == 3'd6) return {1'b0, 4'b0001};
        return {1'b1, 4'b1111};
    endfunction

    function automatic logic [31:0] ref_fwd(logic [4:0] a, logic [31:0] held);
        if (a == 5'd0) return held;
        if (bus.exmem_regwrite && bus.exmem_rd == a) return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == a) return bus.memwb_result;
        return held;
    endfunction

    task automatic model_edge();
        logic [4:0] d;
        if (rst) begin
            m_valid = 0; m_ctl = 4'b0010; m_ill = 0; m_alusrc = 0;
            m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_rw = 0;
        end else if (bus.flush) begin
            m_valid = 0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            d = ref_decode(bus.in_aluop, bus.in_funct3, bus.in_rtype, bus.in_funct7_5);
            m_valid = 1; m_ill = d[4]; m_ctl = d[3:0];
            m_alusrc = bus.in_alusrc; m_rs1d = bus.in_rs1_data; m_rs2d = bus.in_rs2_data;
            m_imm = bus.in_imm; m_rs1a = bus.in_rs1_addr; m_rs2a = bus.in_rs2_addr;
            m_rd = bus.in_rd_addr; m_rw = bus.in_regwrite;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end else if (m_valid && bus.memwb_regwrite && bus.memwb_rd != 5'd0) begin
            if (bus.memwb_rd == m_rs1a) m_rs1d = bus.memwb_result;
            if (bus.memwb_rd == m_rs2a) m_rs2d = bus.memwb_result;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_rs2f;
        e_rs2f = ref_fwd(m_rs2a, m_rs2d);
        chk({tag, ".in_ready"},   32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
        chk({tag, ".out_valid"},  32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".ALUCtl"},     32'(bus.ALUCtl),    32'(m_ctl));
        chk({tag, ".illegal"},    32'(bus.illegal),   32'(m_ill));
        chk({tag, ".rs1"},        bus.rs1,            ref_fwd(m_rs1a, m_rs1d));
        chk({tag, ".rs2"},        bus.rs2,            m_alusrc ? m_imm : e_rs2f);
        chk({tag, ".store_data"}, bus.store_data,     e_rs2f);
        chk({tag, ".rd_addr"},    32'(bus.rd_addr),   32'(m_rd));
        chk({tag, ".regwrite"},   32'(bus.regwrite),  32'(m_rw));
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.in_aluop = 0; bus.in_rtype = 0;
        bus.in_funct7_5 = 0; bus.in_funct3 = 0; bus.in_alusrc = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
        bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0; bus.in_regwrite = 0;
        bus.exmem_regwrite = 0; bus.memwb_regwrite = 0; bus.exmem_rd = 0; bus.memwb_rd = 0;
        bus.exmem_result = 0; bus.memwb_result = 0; bus.out_ready = 1;
    endtask

    initial begin
        m_valid = 0; m_ctl = 0; m_ill = 0; m_alusrc = 0; m_rs1d = 0; m_rs2d = 0;
        m_imm = 0; m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_rw = 0;
        clear_inputs();
        rst = 1;

        // Reset then idle.
        tick(); tick();
        rst = 0;
        tick();
        check_all("reset");
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_ctl",   32'(bus.ALUCtl),    32'h2);
        chk("reset_ready", 32'(bus.in_ready),  32'd1);

        // R-type SUB.
        bus.in_valid = 1; bus.in_aluop = 2'b10; bus.in_rtype = 1; bus.in_funct7_5 = 1;
        bus.in_funct3 = 3'b000; bus.in_rs1_data = 9; bus.in_rs2_data = 4;
        bus.in_rs1_addr = 1; bus.in_rs2_addr = 2; bus.in_rd_addr = 7; bus.in_regwrite = 1;
        tick();
        bus.in_valid = 0;
        #1;
        check_all("rtype");
        chk("rtype_ctl", 32'(bus.ALUCtl), 32'h6);
        chk("rtype_rs1", bus.rs1, 32'd9);
        chk("rtype_rs2", bus.rs2, 32'd4);

        // I-type OR with immediate B.
        bus.in_valid = 1; bus.in_rtype = 0; bus.in_funct7_5 = 0; bus.in_funct3 = 3'b110;
        bus.in_alusrc = 1; bus.in_imm = 32'hF0; bus.in_rs2_addr = 5; bus.in_rs2_data = 7;
        tick();
        bus.in_valid = 0;
        #1;
        check_all("itype");
        chk("itype_ctl",   32'(bus.ALUCtl), 32'h1);
        chk("itype_rs2",   bus.rs2,         32'hF0);
        chk("itype_store", bus.store_data,  32'd7);

        // Forwarding priority on rs1.
        bus.in_valid = 1; bus.in_alusrc = 0; bus.in_funct3 = 3'b000; bus.in_aluop = 2'b00;
        bus.in_rs1_addr = 3; bus.in_rs1_data = 32'hAA;
        tick();
        bus.in_valid = 0;
        bus.exmem_regwrite = 1; bus.exmem_rd = 3; bus.exmem_result = 32'h11;
        bus.memwb_regwrite = 1; bus.memwb_rd = 3; bus.memwb_result = 32'h22;
        #1;
        check_all("fwd_both");
        chk("fwd_exmem", bus.rs1, 32'h11);
        bus.exmem_rd = 0;
        #1;
        check_all("fwd_x0");
        chk("fwd_memwb", bus.rs1, 32'h22);
        bus.exmem_regwrite = 0; bus.memwb_regwrite = 0;

        // Stall with MEM/WB snoop into held rs1.
        bus.in_valid = 1; bus.in_rs1_addr = 3; bus.in_rs1_data = 32'h33; bus.in_rd_addr = 9;
        tick();
        bus.out_ready = 0;
        bus.in_rs1_data = 32'h99; bus.in_rd_addr = 12;
        bus.memwb_regwrite = 1; bus.memwb_rd = 3; bus.memwb_result = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall");
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.memwb_regwrite = 0; bus.in_valid = 0;
        #1;
        chk("snoop_rs1", bus.rs1, 32'h55);
        chk("snoop_rd",  32'(bus.rd_addr), 32'd9);
        bus.out_ready = 1;
        #1;
        check_all("release");
        tick();
        chk("drained", 32'(bus.out_valid), 32'd0);

        // Illegal decode.
        bus.in_valid = 1; bus.in_aluop = 2'b10; bus.in_funct3 = 3'b001;
        tick();
        bus.in_valid = 0;
        #1;
        check_all("illegal");
        chk("illegal_ctl", 32'(bus.ALUCtl),  32'hF);
        chk("illegal_bit", 32'(bus.illegal), 32'd1);

        // Flush with in_valid high: nothing captured.
        bus.in_valid = 1; bus.in_aluop = 2'b01; bus.flush = 1; bus.in_rd_addr = 21;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        #1;
        check_all("flush");
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_rd",    32'(bus.rd_addr),   32'd12);

        // Random traffic with a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.in_valid = $urandom_range(0, 1);
            bus.in_aluop = 2'($urandom_range(0, 3));
            bus.in_rtype = $urandom_range(0, 1);
            bus.in_funct7_5 = $urandom_range(0, 1);
            bus.in_funct3 = 3'($urandom_range(0, 7));
            bus.in_alusrc = $urandom_range(0, 1);
            bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom; bus.in_imm = $urandom;
            bus.in_rs1_addr = 5'($urandom_range(0, 3));
            bus.in_rs2_addr = 5'($urandom_range(0, 3));
            bus.in_rd_addr = 5'($urandom_range(0, 31));
            bus.in_regwrite = $urandom_range(0, 1);
            bus.exmem_regwrite = $urandom_range(0, 1);
            bus.memwb_regwrite = $urandom_range(0, 1);
            bus.exmem_rd = 5'($urandom_range(0, 3));
            bus.memwb_rd = 5'($urandom_range(0, 3));
            bus.exmem_result = $urandom; bus.memwb_result = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check_all("rand");
            tick();
        end
        rst = 0;
        clear_inputs();
        #1;
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
